tpu_instr_decoder: RTL and testbench



---
 rtl/tpu_instr_decoder_pkg.sv | 49 ++++
 rtl/tpu_instr_decoder.sv | 134 +++++++++++++
 tb/tb_tpu_instr_decoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_instr_decoder_pkg.sv
// Shared types and constants for the TPU instruction decoder: raw field
// positions, opcodes, decoded instruction layout and tile-count helper.
package tpu_instr_decoder_pkg;

    localparam int unsigned INSTR_SIZE = 52;
    localparam int unsigned MUL_SIZE   = 32;
    localparam int unsigned CNT_W      = 16;

    localparam int unsigned OP_W       = 3;
    localparam int unsigned DIM_W      = 8;
    localparam int unsigned DIM1_W     = 7;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DEC_W      = 72;
    localparam int unsigned TILE_SHIFT = $clog2(MUL_SIZE);

    // Raw instruction bit positions
    localparam int unsigned RSV_BIT  = 51;
    localparam int unsigned OP_LSB   = 48;
    localparam int unsigned V_LSB    = 40;
    localparam int unsigned U_LSB    = 32;
    localparam int unsigned ITER_LSB = 24;
    localparam int unsigned RD_LSB   = 12;
    localparam int unsigned WR_LSB   = 0;

    localparam logic [OP_W-1:0] OP_HALT    = 3'b111;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'b110;

    typedef struct packed {
        logic [OP_W-1:0]   mac_op;
        logic [DIM_W-1:0]  v_dim;
        logic [DIM_W-1:0]  u_dim;
        logic [DIM_W-1:0]  iter_dim;
        logic [DIM1_W-1:0] v_dim1;
        logic [DIM1_W-1:0] u_dim1;
        logic [DIM1_W-1:0] iter_dim1;
        logic [ADDR_W-1:0] ub_start_addr_rd;
        logic [ADDR_W-1:0] ub_start_addr_wr;
    } decoded_instr_t;

    // Number of array tiles covering a dimension, minus one: ceil(dim/MUL_SIZE)-1
    function automatic logic [DIM1_W-1:0] tiles_minus1(input logic [DIM_W-1:0] dim);
        logic [DIM_W:0] sum;
        logic [DIM_W:0] tiles;
        sum   = (DIM_W+1)'(dim) + (DIM_W+1)'(MUL_SIZE - 1);
        tiles = sum >> TILE_SHIFT;
        return DIM1_W'(tiles - (DIM_W+1)'(1));
    endfunction

endpackage

// File: rtl/tpu_instr_decoder.sv
// Validates raw host instructions, derives tile counts, and forwards legal
// ones to the control unit through a single registered output stage.
module tpu_instr_decoder
    import tpu_instr_decoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_SIZE-1:0] instr_in,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [DEC_W-1:0]      dec_instr,
    input  logic                  resume,
    output logic                  halted,
    output logic                  err_illegal,
    output logic [CNT_W-1:0]      instr_count,
    output logic [CNT_W-1:0]      err_count
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_e;

    state_e               state_q, state_d;
    logic                 dec_valid_q, dec_valid_d;
    decoded_instr_t       dec_instr_q, dec_instr_d;
    logic                 err_illegal_q, err_illegal_d;
    logic [CNT_W-1:0]     instr_count_q, instr_count_d;
    logic [CNT_W-1:0]     err_count_q, err_count_d;

    logic [OP_W-1:0]      op_c;
    logic [DIM_W-1:0]     v_c, u_c, iter_c;
    logic                 is_illegal_c;
    logic                 is_halt_c;
    logic                 accept_c;
    logic                 xfer_c;
    decoded_instr_t       decoded_c;

    // Field extraction and classification of the raw instruction
    always_comb begin
        op_c   = instr_in[OP_LSB +: OP_W];
        v_c    = instr_in[V_LSB +: DIM_W];
        u_c    = instr_in[U_LSB +: DIM_W];
        iter_c = instr_in[ITER_LSB +: DIM_W];

        is_illegal_c = instr_in[RSV_BIT] || (v_c == '0) || (u_c == '0) ||
                       (iter_c == '0) || (op_c == OP_ILLEGAL);
        is_halt_c    = (op_c == OP_HALT);

        decoded_c.mac_op           = op_c;
        decoded_c.v_dim            = v_c;
        decoded_c.u_dim            = u_c;
        decoded_c.iter_dim         = iter_c;
        decoded_c.v_dim1           = tiles_minus1(v_c);
        decoded_c.u_dim1           = tiles_minus1(u_c);
        decoded_c.iter_dim1        = tiles_minus1(iter_c);
        decoded_c.ub_start_addr_rd = instr_in[RD_LSB +: ADDR_W];
        decoded_c.ub_start_addr_wr = instr_in[WR_LSB +: ADDR_W];
    end

    // Ready depends on dec_ready combinationally; there is no skid buffer
    assign instr_ready = (state_q == ST_RUN) && (!dec_valid_q || dec_ready);
    assign accept_c    = instr_valid && instr_ready;
    assign xfer_c      = dec_valid_q && dec_ready;

    always_comb begin
        state_d       = state_q;
        dec_valid_d   = dec_valid_q;
        dec_instr_d   = dec_instr_q;
        err_illegal_d = err_illegal_q;
        instr_count_d = instr_count_q;
        err_count_d   = err_count_q;

        if (xfer_c) begin
            dec_valid_d = 1'b0;
        end

        if (accept_c) begin
            if (is_illegal_c) begin
                err_illegal_d = 1'b1;
                if (err_count_q != {CNT_W{1'b1}}) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
            end else if (!is_halt_c) begin
                dec_valid_d   = 1'b1;
                dec_instr_d   = decoded_c;
                instr_count_d = instr_count_q + CNT_W'(1);
            end
        end

        // Accepts only occur in RUN, so a same-cycle resume never cancels a HALT
        case (state_q)
            ST_RUN: begin
                if (accept_c && !is_illegal_c && is_halt_c) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            dec_valid_q   <= 1'b0;
            dec_instr_q   <= '0;
            err_illegal_q <= 1'b0;
            instr_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            dec_valid_q   <= dec_valid_d;
            dec_instr_q   <= dec_instr_d;
            err_illegal_q <= err_illegal_d;
            instr_count_q <= instr_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign dec_valid   = dec_valid_q;
    assign dec_instr   = dec_instr_q;
    assign halted      = (state_q == ST_HALTED);
    assign err_illegal = err_illegal_q;
    assign instr_count = instr_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_tpu_instr_decoder.sv
// Self-checking bench for tpu_instr_decoder: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_tpu_instr_decoder;
    import tpu_instr_decoder_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  instr_valid = 1'b0;
    logic                  instr_ready;
    logic [INSTR_SIZE-1:0] instr_in = '0;
    logic                  dec_valid;
    logic                  dec_ready = 1'b0;
    logic [DEC_W-1:0]      dec_instr;
    logic                  resume = 1'b0;
    logic                  halted;
    logic                  err_illegal;
    logic [CNT_W-1:0]      instr_count;
    logic [CNT_W-1:0]      err_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    decoded_instr_t m_q[$];
    bit             m_halted;
    bit             m_err;
    int             m_icnt;
    int             m_ecnt;

    tpu_instr_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_in    (instr_in),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .resume      (resume),
        .halted      (halted),
        .err_illegal (err_illegal),
        .instr_count (instr_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_SIZE-1:0] mk(input logic rsv, input int op, input int v,
                                                 input int u, input int it, input int rd,
                                                 input int wr);
        return {rsv, 3'(op), 8'(v), 8'(u), 8'(it), 12'(rd), 12'(wr)};
    endfunction

    // Expected decode computed from the field meanings with integer arithmetic
    function automatic decoded_instr_t ref_dec(input logic [INSTR_SIZE-1:0] r);
        decoded_instr_t d;
        int v, u, it;
        v  = int'(r[47:40]);
        u  = int'(r[39:32]);
        it = int'(r[31:24]);
        d.mac_op           = r[50:48];
        d.v_dim            = 8'(v);
        d.u_dim            = 8'(u);
        d.iter_dim         = 8'(it);
        d.v_dim1           = 7'((v - 1) / 32);
        d.u_dim1           = 7'((u - 1) / 32);
        d.iter_dim1        = 7'((it - 1) / 32);
        d.ub_start_addr_rd = r[23:12];
        d.ub_start_addr_wr = r[11:0];
        return d;
    endfunction

    task automatic chk(input string tag, input logic [DEC_W-1:0] obs, input logic [DEC_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("dec_valid", 72'(dec_valid), 72'(m_q.size() != 0));
        chk("halted", 72'(halted), 72'(m_halted));
        chk("err_illegal", 72'(err_illegal), 72'(m_err));
        chk("instr_count", 72'(instr_count), 72'(m_icnt % 65536));
        chk("err_count", 72'(err_count), 72'((m_ecnt > 65535) ? 65535 : m_ecnt));
        if (m_q.size() != 0) chk("dec_instr", dec_instr, 72'(m_q[0]));
    endtask

    // One clock: check ready, advance the model across the edge, check outputs
    task automatic cycle();
        bit rdy, acc, xfer, ill, hlt;
        logic [INSTR_SIZE-1:0] r;
        #1;
        rdy  = !m_halted && (m_q.size() == 0 || dec_ready);
        xfer = (m_q.size() != 0) && dec_ready;
        acc  = instr_valid && rdy;
        r    = instr_in;
        if (!rst) chk("instr_ready", 72'(instr_ready), 72'(rdy));
        ill = r[51] || (r[47:40] == 0) || (r[39:32] == 0) || (r[31:24] == 0) || (r[50:48] == 3'd6);
        hlt = (r[50:48] == 3'd7);
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_halted = 0;
            m_err    = 0;
            m_icnt   = 0;
            m_ecnt   = 0;
        end else begin
            if (xfer) void'(m_q.pop_front());
            if (acc) begin
                if (ill) begin
                    m_err = 1;
                    m_ecnt++;
                end else if (!hlt) begin
                    m_q.push_back(ref_dec(r));
                    m_icnt++;
                end
            end
            if (m_halted) begin
                if (resume) m_halted = 0;
            end else if (acc && !ill && hlt) begin
                m_halted = 1;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        decoded_instr_t obs;

        // Reset
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("reset_ready", 72'(instr_ready), 72'(1));
        chk("reset_valid", 72'(dec_valid), 72'(0));
        chk("reset_instr", dec_instr, 72'(0));

        // Basic forward
        dec_ready   = 1'b1;
        instr_valid = 1'b1;
        instr_in    = mk(1'b0, 1, 64, 33, 255, 'h010, 'h800);
        cycle();
        instr_valid = 1'b0;
        obs = decoded_instr_t'(dec_instr);
        chk("basic_v_dim1", 72'(obs.v_dim1), 72'(1));
        chk("basic_u_dim1", 72'(obs.u_dim1), 72'(1));
        chk("basic_iter_dim1", 72'(obs.iter_dim1), 72'(7));
        chk("basic_rd", 72'(obs.ub_start_addr_rd), 72'('h010));
        chk("basic_wr", 72'(obs.ub_start_addr_wr), 72'('h800));
        chk("basic_count", 72'(instr_count), 72'(1));
        cycle();

        // Backpressure with three back-to-back instructions
        dec_ready   = 1'b0;
        instr_valid = 1'b1;
        instr_in    = mk(1'b0, 2, 10, 20, 30, 1, 2);
        cycle();
        instr_in    = mk(1'b0, 3, 40, 50, 60, 3, 4);
        repeat (4) cycle();
        dec_ready = 1'b1;
        cycle();
        instr_in  = mk(1'b0, 4, 70, 80, 90, 5, 6);
        cycle();
        instr_valid = 1'b0;
        cycle();
        cycle();
        chk("bp_count", 72'(instr_count), 72'(4));

        // Illegal instructions
        instr_valid = 1'b1;
        instr_in    = mk(1'b0, 1, 5, 0, 5, 0, 0);
        cycle();
        chk("ill1_err", 72'(err_illegal), 72'(1));
        instr_in = mk(1'b1, 1, 5, 5, 5, 0, 0);
        cycle();
        chk("ill2_cnt", 72'(err_count), 72'(2));
        instr_in = mk(1'b0, 6, 5, 5, 5, 0, 0);
        cycle();
        chk("ill3_cnt", 72'(err_count), 72'(3));
        instr_in = mk(1'b0, 5, 100, 100, 100, 'hABC, 'h123);
        cycle();
        instr_valid = 1'b0;
        cycle();

        // HALT then resume
        instr_valid = 1'b1;
        instr_in    = mk(1'b0, 7, 1, 1, 1, 0, 0);
        cycle();
        chk("halt_halted", 72'(halted), 72'(1));
        instr_in = mk(1'b0, 0, 2, 3, 4, 7, 8);
        repeat (3) cycle();
        resume = 1'b1;
        cycle();
        resume = 1'b0;
        cycle();
        instr_valid = 1'b0;
        cycle();

        // Resume coinciding with a HALT accept is ignored
        instr_valid = 1'b1;
        instr_in    = mk(1'b0, 7, 9, 9, 9, 0, 0);
        resume      = 1'b1;
        cycle();
        chk("halt_resume_same", 72'(halted), 72'(1));
        instr_valid = 1'b0;
        resume      = 1'b0;
        cycle();
        resume = 1'b1;
        cycle();
        resume = 1'b0;
        cycle();

        // Boundary tile counts
        instr_valid = 1'b1;
        instr_in    = mk(1'b0, 1, 1, 32, 33, 0, 0);
        cycle();
        obs = decoded_instr_t'(dec_instr);
        chk("bnd_1", 72'(obs.v_dim1), 72'(0));
        chk("bnd_32", 72'(obs.u_dim1), 72'(0));
        chk("bnd_33", 72'(obs.iter_dim1), 72'(1));
        instr_in = mk(1'b0, 1, 255, 255, 255, 0, 0);
        cycle();
        obs = decoded_instr_t'(dec_instr);
        chk("bnd_255", 72'(obs.v_dim1), 72'(7));
        instr_valid = 1'b0;
        cycle();

        // Reset while a decoded instruction is stalled
        dec_ready   = 1'b0;
        instr_valid = 1'b1;
        instr_in    = mk(1'b0, 2, 8, 8, 8, 1, 1);
        cycle();
        instr_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_valid", 72'(dec_valid), 72'(0));
        chk("rst_icnt", 72'(instr_count), 72'(0));
        chk("rst_err", 72'(err_illegal), 72'(0));
        chk("rst_halted", 72'(halted), 72'(0));
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            instr_valid = ($urandom_range(0, 3) != 0);
            dec_ready   = ($urandom_range(0, 3) != 0);
            resume      = ($urandom_range(0, 5) == 0);
            instr_in    = mk(($urandom_range(0, 15) == 0),
                             int'($urandom_range(0, 7)),
                             ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255)),
                             ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255)),
                             ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255)),
                             int'($urandom_range(0, 4095)),
                             int'($urandom_range(0, 4095)));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
